// File: rtl/dmem_mmio_slave.sv
// rtl/dmem_mmio_slave.sv - data-memory responder: word RAM plus GPIO/timer MMIO bank
// Optional timer (MTIME, MTIMECMP, STATUS, IRQ_TIMER) is built only with DMEM_TIMER_EN defined.
module dmem_mmio_slave #(
    parameter int DEPTH  = 1024,
    parameter int GPIO_W = 8
) (
    input  logic              CLK,
    input  logic              RSTa,
    input  logic [31:0]       DIR_DMEM,
    input  logic [31:0]       DATA_WRITE_DMEM,
    input  logic              READ,
    input  logic              WRITE,
    output logic [31:0]       DATA_READ_DMEM,
    input  logic [GPIO_W-1:0] GPIO_IN,
    output logic [GPIO_W-1:0] GPIO_OUT,
    output logic              IRQ_TIMER
);

    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [3:0] REG_GPIO_OUT = 4'd0;
    localparam logic [3:0] REG_GPIO_IN  = 4'd1;
    localparam logic [3:0] REG_MTIME    = 4'd2;
    localparam logic [3:0] REG_MTIMECMP = 4'd3;
    localparam logic [3:0] REG_STATUS   = 4'd4;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] ram_idx;
    logic [3:0]        reg_sel;
    logic              sel_mmio;
    logic              ram_we;
    logic              mmio_we;

    logic [GPIO_W-1:0] gpio_out;
    logic [GPIO_W-1:0] gpio_meta;
    logic [GPIO_W-1:0] gpio_sync;
    logic [31:0]       gpio_out_rd;
    logic [31:0]       gpio_in_rd;
    logic [31:0]       timer_rd;
    logic              unused_bits;

    assign ram_idx  = DIR_DMEM[ADDR_W-1:0];
    assign reg_sel  = DIR_DMEM[3:0];
    assign sel_mmio = DIR_DMEM[31];
    // RAM has no reset, so a store coinciding with reset is blocked here instead.
    assign ram_we   = WRITE & ~sel_mmio & RSTa;
    assign mmio_we  = WRITE & sel_mmio;

    assign unused_bits = ^{DIR_DMEM, DATA_WRITE_DMEM};

    always_ff @(posedge CLK) begin
        if (ram_we) begin
            mem[ram_idx] <= DATA_WRITE_DMEM;
        end
    end

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            gpio_out  <= '0;
            gpio_meta <= '0;
            gpio_sync <= '0;
        end else begin
            gpio_meta <= GPIO_IN;
            gpio_sync <= gpio_meta;
            if (mmio_we && reg_sel == REG_GPIO_OUT) begin
                gpio_out <= DATA_WRITE_DMEM[GPIO_W-1:0];
            end
        end
    end

    assign GPIO_OUT = gpio_out;

    always_comb begin
        gpio_out_rd = '0;
        gpio_in_rd  = '0;
        gpio_out_rd[GPIO_W-1:0] = gpio_out;
        gpio_in_rd[GPIO_W-1:0]  = gpio_sync;
    end

`ifdef DMEM_TIMER_EN
    logic [31:0] mtime;
    logic [31:0] mtimecmp;
    logic        tflag;

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            mtime    <= '0;
            mtimecmp <= 32'hFFFF_FFFF;
            tflag    <= 1'b0;
        end else begin
            if (mmio_we && reg_sel == REG_MTIME) begin
                mtime <= DATA_WRITE_DMEM;
            end else begin
                mtime <= mtime + 32'd1;
            end
            if (mmio_we && reg_sel == REG_MTIMECMP) begin
                mtimecmp <= DATA_WRITE_DMEM;
            end
            // A match in the same cycle as a software clear keeps the flag set.
            if (mtime == mtimecmp) begin
                tflag <= 1'b1;
            end else if (mmio_we && reg_sel == REG_STATUS && DATA_WRITE_DMEM[0]) begin
                tflag <= 1'b0;
            end
        end
    end

    assign IRQ_TIMER = tflag;

    always_comb begin
        case (reg_sel)
            REG_MTIME:    timer_rd = mtime;
            REG_MTIMECMP: timer_rd = mtimecmp;
            REG_STATUS:   timer_rd = {31'd0, tflag};
            default:      timer_rd = '0;
        endcase
    end
`else
    assign IRQ_TIMER = 1'b0;
    assign timer_rd  = '0;
`endif

    always_comb begin
        DATA_READ_DMEM = '0;
        if (READ) begin
            if (!sel_mmio) begin
                DATA_READ_DMEM = mem[ram_idx];
            end else begin
                case (reg_sel)
                    REG_GPIO_OUT: DATA_READ_DMEM = gpio_out_rd;
                    REG_GPIO_IN:  DATA_READ_DMEM = gpio_in_rd;
                    default:      DATA_READ_DMEM = timer_rd;
                endcase
            end
        end
    end

endmodule

// File: doc/dmem_mmio_slave.md
# dmem_mmio_slave

Data-memory responder for the single-cycle RISC-V core: it sits at the far end of the core's data-memory port (address, write data, READ/WRITE strobes, read-data return) and serves every load/store issued by the core. The low half of the address space maps to a word-organised RAM. The high half maps to a small bank of memory-mapped registers: a GPIO output latch, a synchronised GPIO input, and a free-running timer with compare and sticky interrupt flag. Reads return data in the same cycle, as required by the single-cycle datapath; all state updates happen on the rising edge of CLK.

## Interface
- DEPTH, 1024: RAM size in 32-bit words; power of two; ADDR_W = log2(DEPTH).
- GPIO_W, 8: width of the GPIO output and input ports, 1..32.
- CLK  in  1  system clock.
- RSTa  in  1  asynchronous, active-low reset; clock CLK.
- DIR_DMEM  in  32  word address from the core.
- DATA_WRITE_DMEM  in  32  store data.
- READ  in  1  load strobe.
- WRITE  in  1  store strobe.
- DATA_READ_DMEM  out  32  load data, combinational.
- GPIO_IN  in  GPIO_W  asynchronous external inputs.
- GPIO_OUT  out  GPIO_W  GPIO output latch.
- IRQ_TIMER  out  1  timer interrupt; equals STATUS.TFLAG.

## Operation
- Addresses are word addresses. Region select is DIR_DMEM[31]:
  - 0 selects RAM; the index is DIR_DMEM[ADDR_W-1:0] and higher bits are ignored (aliasing wrap).
  - 1 selects MMIO; the register is selected by DIR_DMEM[3:0] and bits [30:4] are ignored.
- MMIO map:
  - 0 GPIO_OUT: RW, reset 0; only the low GPIO_W bits are stored, upper read bits are 0.
  - 1 GPIO_IN: RO; value after a 2-flop synchroniser, reset 0.
  - 2 MTIME: RW, reset 0; increments by 1 every cycle and wraps from 0xFFFF_FFFF to 0. A store loads DATA_WRITE_DMEM, and the load wins over that cycle's increment.
  - 3 MTIMECMP: RW, reset 0xFFFF_FFFF.
  - 4 STATUS: bit0 TFLAG, reset 0; bits [31:1] read 0. Writing 1 to bit0 clears TFLAG (write-one-to-clear); writing 0 has no effect.
  - 5..15: read 0; writes are ignored.
- TFLAG set condition: the registered MTIME equals MTIMECMP. TFLAG is sticky until cleared by software.
- Simultaneous set and write-one-to-clear in the same cycle: set wins.
- READ=0: DATA_READ_DMEM = 0.
- READ=1: DATA_READ_DMEM returns the current, pre-edge contents of the addressed location.
- READ=1 and WRITE=1 together: the read returns the old value and the write commits at the edge.
- WRITE=1 on a read-only or unmapped register: no state change.
- RAM contents are not reset. Reset clears every MMIO register to its value listed above, asynchronously.

## Timing
- Load latency is 0 cycles; the read path from address to DATA_READ_DMEM is combinational.
- Store commit: at the rising CLK edge where WRITE=1; the new value is visible to a read in the following cycle.
- GPIO_OUT changes at the same edge as the store that writes it.
- GPIO_IN latency is 2 cycles from the external input to a readable value.
- TFLAG and IRQ_TIMER go high at the edge after the cycle in which MTIME == MTIMECMP.
- Reset asserted mid-operation: all outputs are forced to their reset values immediately (GPIO_OUT=0, IRQ_TIMER=0). A store in flight during reset is discarded.

## Configuration
- DMEM_TIMER_EN defined: MTIME, MTIMECMP and STATUS are implemented exactly as described above.
- DMEM_TIMER_EN undefined:
  - MMIO addresses 2..4 behave as unmapped (read 0, writes ignored).
  - IRQ_TIMER is tied to 0.
  - No timer flops are synthesised.
  - RAM and GPIO behaviour are unchanged.

## Test plan
- RAM store/load, read-before-write and aliasing:
  - Store 0xDEADBEEF to address 5, then load address 5: returns 0xDEADBEEF the cycle after the store.
  - READ and WRITE together to address 5 with data 0x1234: returns 0xDEADBEEF in that cycle and 0x1234 afterwards.
  - With DEPTH=1024, a load from address 0x405 returns the same word as address 5.
- GPIO path:
  - Store 0xFFFF_FFA5 to 0x8000_0000: GPIO_OUT=0xA5 and a read returns 0x0000_00A5.
  - Drive GPIO_IN=0x3C: a read of 0x8000_0001 returns 0x3C from the third cycle onward.
- Timer compare:
  - Store MTIME=10 and MTIMECMP=20.
  - TFLAG and IRQ_TIMER rise exactly 11 cycles after the MTIME store edge and stay high.
  - Store 1 to STATUS: both fall at the next edge.
- Flag contention and wrap:
  - Set MTIMECMP=0 and MTIME=0xFFFF_FFFE.
  - MTIME wraps to 0 two cycles later and TFLAG sets.
  - A clear issued in the same cycle as the set condition leaves TFLAG=1.
- Reset mid-operation:
  - With GPIO_OUT=0xA5, TFLAG=1 and MTIME running, pulse RSTa low between clock edges.
  - GPIO_OUT=0, IRQ_TIMER=0, MTIME reads 0 and MTIMECMP reads 0xFFFF_FFFF immediately; previously written RAM words are unchanged.
- Without DMEM_TIMER_EN: reads of 0x8000_0002..4 return 0, IRQ_TIMER stays 0 under all stimulus, and GPIO and RAM tests pass unchanged.
